// File: rtl/logic_reduce_acc_if.sv
// Handshake bundle for logic_reduce_acc: input beat channel plus result channel.
// master = stimulus/consumer side, slave = the reduction block.
interface logic_reduce_acc_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    in_last;
  logic [2:0]              op;
  logic                    mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_parity;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_data, in_last, op, mode, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, op, mode, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_count
  );
endinterface

// File: rtl/logic_reduce_acc.sv
// Registered bitwise AND/OR/XOR reducer over NUM_IN channels, per-beat or
// folded across a multi-beat frame, with optional final inversion.
module logic_reduce_acc #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_reduce_acc_if.slave     bus
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  acc, acc_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [2:0]        op_l, op_l_n;

  logic [WIDTH-1:0]  red_and, red_or, red_xor;
  logic [WIDTH-1:0]  beat_live, fold_acc;
  logic [WIDTH-1:0]  res_data;
  logic [CNT_W-1:0]  res_count;
  logic              load, accept;

  function automatic logic [WIDTH-1:0] pick(input logic [1:0] o,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] r,
                                            input logic [WIDTH-1:0] x);
    case (o)
      2'b00:   pick = a;
      2'b10:   pick = x;
      default: pick = r;
    endcase
  endfunction

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      red_and = red_and & bus.in_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | bus.in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Each op is associative, so folding acc with the same-op reduction of the
  // new beat equals reducing every channel of every beat in the frame.
  assign beat_live = pick(bus.op[1:0], red_and, red_or, red_xor);
  assign fold_acc  = pick(op_l[1:0], acc & red_and, acc | red_or, acc ^ red_xor);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    op_l_n    = op_l;
    load      = 1'b0;
    res_data  = '0;
    res_count = '0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!bus.mode || bus.in_last) begin
            load      = 1'b1;
            res_data  = beat_live ^ {WIDTH{bus.op[2]}};
            res_count = CNT_W'(1);
          end else begin
            op_l_n  = bus.op;
            acc_n   = beat_live;
            cnt_n   = CNT_W'(1);
            state_n = ACC;
          end
        end
        ACC: begin
          acc_n = fold_acc;
          cnt_n = cnt_inc;
          if (bus.in_last) begin
            load      = 1'b1;
            res_data  = fold_acc ^ {WIDTH{op_l[2]}};
            res_count = cnt_inc;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_l  <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      op_l  <= op_l_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_parity <= 1'b0;
      bus.out_count  <= '0;
    end else if (load) begin
      bus.out_valid  <= 1'b1;
      bus.out_data   <= res_data;
      bus.out_parity <= ^res_data;
      bus.out_count  <= res_count;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/logic_reduce_acc.md
# logic_reduce_acc

Parametrised, registered bitwise logic unit. Each accepted beat carries NUM_IN channels of WIDTH bits, which the block reduces bitwise with a selectable AND/OR/XOR operation and optional output inversion. In per-beat mode every input beat produces one result. In accumulate mode the block folds a multi-beat frame into one result. It sits between a lab stimulus source (switch/FIFO) and a display/result register, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: bit width of each channel and of the result (≥1).
- NUM_IN, 4: number of channels reduced per beat (≥2).
- CNT_W, 8: width of the frame beat counter.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_last  input  1  last beat of frame (accumulate mode only; ignored in per-beat mode).
- op  input  3  op[1:0]: 00 AND, 01 OR, 10 XOR, 11 treated as OR; op[2]=1 inverts the final result (NAND/NOR/XNOR).
- mode  input  1  0 = per-beat, 1 = accumulate frame.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_parity  output  1  XOR of all bits of out_data.
- out_count  output  CNT_W  beats folded into this result (1 in per-beat mode); saturates at 2^CNT_W−1.

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- Beat reduction R = ch0 op ch1 op … op ch(NUM_IN−1), computed bitwise without inversion.
- FSM has two states, IDLE and ACC. Reset state is IDLE.
- IDLE, accepted beat, mode=0:
  - out_data ← R, inverted if op[2]; out_count ← 1; out_valid ← 1.
  - Stays in IDLE.
- IDLE, accepted beat, mode=1:
  - op and mode are latched for the frame.
  - If in_last: behaves as a one-beat frame (result as mode=0, out_count ← 1). Stays in IDLE.
  - Else: acc ← R; cnt ← 1; go to ACC.
- ACC, accepted beat:
  - Uses the latched op. Live op and mode are ignored until the frame ends.
  - acc ← acc op_latched R; cnt ← cnt+1, saturating.
  - If in_last: out_data ← final acc (inverted if latched op[2]); out_count ← cnt+1 (saturating); out_valid ← 1; go to IDLE.
- Inversion is applied once, to the final result only, never to intermediate acc.
- out_valid clears on out_valid && out_ready unless a new result loads in the same cycle, in which case it stays 1 with new data.
- out_data, out_count and out_parity stay stable while out_valid=1 and out_ready=0.
- Non-last beats in ACC are accepted only when in_ready=1. This is deliberately conservative and simplifies the spec.

## Timing
- Reset (synchronous, takes effect at the clk edge with rst=1):
  - out_valid=0, out_data=0, out_parity=0, out_count=0.
  - State returns to IDLE; acc=0, cnt=0.
  - A partially accumulated frame is discarded with no output.
- rst has priority over any concurrent handshake.
- Latency:
  - Per-beat: result visible with out_valid=1 in the cycle after acceptance.
  - Accumulate: result appears one cycle after the in_last beat is accepted.
- Throughput: one beat per cycle when out_ready is held high.
- Backpressure:
  - With out_valid=1 and out_ready=0, in_ready=0 and no state changes.
  - Upstream must hold in_data, in_last, op and mode stable while in_valid=1 and in_ready=0.
- Simultaneous output pop and input accept: the new result replaces the old one at the same edge, with no bubble.
- out_count saturation: frames longer than 2^CNT_W−1 beats report 2^CNT_W−1. The fold result remains correct.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 2 cycles mid-frame (after 2 accumulated beats), then a 1-beat frame of 0x01 with op=OR.
  - Required: all outputs are 0 after reset; the result is 0x01 with out_count=1, so the earlier beats did not leak.
- Per-beat ops:
  - Stimulus: channels {0x0F, 0xF0, 0x3C, 0x00} with WIDTH=8, NUM_IN=4, out_ready=1.
  - Required results:
    - AND → 0x00, parity 0.
    - OR → 0xFF, parity 0.
    - XOR → 0xC3, parity 0.
    - NAND → 0xFF.
    - NOR → 0x00.
    - XNOR → 0x3C.
  - Each result appears 1 cycle after its beat.
- Accumulate:
  - Stimulus: mode=1, op=OR, ch0 beats 0x01, 0x02, 0x04 with in_last on the third; other channels 0.
  - Required: out_data=0x07, out_count=3, out_parity=1.
  - Stimulus: XNOR frame with ch0 beats 0xFF, 0x0F.
  - Required: out_data=0x0F, out_count=2.
- Op latch:
  - Stimulus: start an OR frame, then change op to AND mid-frame; beats 0x10, 0x01 (last).
  - Required: out_data=0x11.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: in_ready=0 throughout and out_data stable; on release, one pop plus one accept occur in the same cycle and the next result follows.
- Saturation:
  - Stimulus: CNT_W=2, 5-beat XOR frame of ch0 beats 0x01.
  - Required: out_count=3, out_data=0x01.
